bool_truth_table_scanner: RTL and testbench
===========================================

Name: bool_truth_table_scanner

Overview:
- Sequential test harness that sits on both sides of a 4-input combinational boolean-expression block.
- Upstream role: drives a,b,c,d through all 16 minterms in order.
- Downstream role: samples the expression output `f_in` for each minterm, builds a 16-bit truth table and compares it against an expected mask.
- Used to self-check expression blocks in place, e.g. the dataflow and gate-level forms of abc+a'c'+d.

Parameters:
- SETTLE_CYCLES, default 1 — cycles each minterm is held before `f_in` is sampled; legal range 1..15.

Ports:
- clk  input  1  — single clock, rising edge.
- rst  input  1  — asynchronous, active-high reset.
- start  input  1  — scan request; accepted only in IDLE.
- expected  input  16  — expected truth table, bit i = f(minterm i); captured on accepted start.
- a  output  1  — minterm index bit 3 (MSB).
- b  output  1  — minterm index bit 2.
- c  output  1  — minterm index bit 1.
- d  output  1  — minterm index bit 0 (LSB).
- f_in  input  1  — output of the expression block under test.
- busy  output  1  — high while scanning.
- done  output  1  — one-cycle pulse when a scan completes.
- table_out  output  16  — captured truth table.
- match  output  1  — table_out == captured expected; valid from done, held until next start.
- mismatch_count  output  5  — number of mismatching minterms, 0..16.
- fail_valid  output  1  — at least one mismatch seen in the current or last scan.
- first_fail_idx  output  4  — index of the lowest-numbered mismatching minterm; valid when fail_valid=1.

Behaviour:
- Reset (async, immediate): state=IDLE; idx=0; settle cnt=0; {a,b,c,d}=0; busy=0; done=0; table_out=0; match=0; mismatch_count=0; fail_valid=0; first_fail_idx=0; expected register=0.
- {a,b,c,d} is driven from registered idx at all times (a=idx[3]), so there is no combinational path from `start`.
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - start=1 at edge k → SETTLE; idx=0; cnt=0.
  - Same edge: expected register←expected; table_out←0; mismatch_count←0; fail_valid←0; first_fail_idx←0; match←0.
- SETTLE:
  - busy=1.
  - Each edge with cnt<SETTLE_CYCLES-1: cnt++.
  - At the edge with cnt==SETTLE_CYCLES-1 (sample edge):
    - table_out[idx]←f_in.
    - If f_in != exp[idx]: mismatch_count++. If fail_valid==0: first_fail_idx←idx and fail_valid←1.
    - If idx==15: → DONE, and match←(final table == exp), including this sample. Otherwise idx++, cnt←0.
- Timing: sample edges fall at k+S, k+2S, …, k+16S (S=SETTLE_CYCLES).
- DONE:
  - done=1 and busy=0 for exactly one cycle, which follows edge k+16S.
  - Next edge → IDLE.
  - {a,b,c,d} holds 4'hF in DONE, then returns to 0 on entering IDLE.
- Start handling: start in SETTLE or DONE is ignored; the scan is not restarted. start held high continuously gives back-to-back scans with one IDLE cycle between them.
- Input changes: changes to `expected` mid-scan have no effect; only the copy captured at start is used.
- Hold: results (table_out, match, counts) hold after DONE until the next accepted start.
- Reset mid-scan: aborts immediately to reset values; no done pulse.
- Width rules: mismatch_count saturates naturally at 16 (5 bits, no wrap); idx is 4 bits and is never incremented past 15.

Decomposition:
- Package bool_scan_pkg holds:
  - state enum {IDLE, SETTLE, DONE}
  - NUM_MINTERMS=16
  - IDX_W=4
  - CNT_W=4
- Sub-module bool_scan_settle_timer: cnt register, clear/enable inputs, `expire` output at SETTLE_CYCLES-1.
- Compare/capture logic stays in the top module.

Test Plan:
- DUT = abc+a'c'+d, S=1, expected=16'hEABB, start pulse at edge k → match=1, mismatch_count=0, fail_valid=0, table_out=16'hEABB, done pulse in the cycle after edge k+16.
- DUT = abc+a'c'+d, expected=16'hEABA → match=0, mismatch_count=1, fail_valid=1, first_fail_idx=0.
- DUT = a(b+c) (abc'd+ab'cd+abc'+ac), expected=16'h0000 → table_out=16'hFC00, mismatch_count=6, first_fail_idx=10.
- S=3, start at edge k, f_in tied 1, expected=16'hFFFF → a..d hold each minterm 3 cycles, done in the cycle after edge k+48, match=1.
- start re-pulsed at scan cycle 5, and `expected` changed mid-scan → ignored, results identical to an undisturbed run.
- rst asserted asynchronously mid-edge during idx=7 → all outputs 0 immediately, no done; a new start then completes a full, correct scan.

Source files
------------

// File: rtl/bool_scan_pkg.sv
// Shared types and sizes for the boolean truth-table scanner.
// Minterm index and settle counter are both 4 bits wide.
package bool_scan_pkg;

    localparam int NUM_MINTERMS = 16;
    localparam int IDX_W        = 4;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/bool_scan_settle_timer.sv
// Per-minterm settle counter: counts up while enabled and flags the sample cycle.
// The count freezes at its terminal value until cleared.
module bool_scan_settle_timer
    import bool_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/bool_truth_table_scanner.sv
// Walks a,b,c,d through all 16 minterms, samples f_in after a settle delay,
// and compares the resulting truth table against the mask captured at start.
//
// state  | meaning
// IDLE   | waiting for start; results of the last scan held
// SETTLE | driving minterm idx, sampling f_in when the timer expires
// DONE   | one-cycle done pulse, {a,b,c,d} still 4'hF
module bool_truth_table_scanner
    import bool_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        f_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        match,
    output logic [4:0]  mismatch_count,
    output logic        fail_valid,
    output logic [3:0]  first_fail_idx
);

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [NUM_MINTERMS-1:0] exp_q;
    logic [NUM_MINTERMS-1:0] sample_table;
    logic                    sample_miss;
    logic                    expire;
    logic                    last_idx;

    bool_scan_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear ((state_q != SETTLE) || expire),
        .enable(state_q == SETTLE),
        .expire(expire)
    );

    // Table as it will look after this cycle's sample; used for the final match too.
    always_comb begin
        sample_table        = table_out;
        sample_table[idx_q] = f_in;
    end

    assign sample_miss = (f_in != exp_q[idx_q]);
    assign last_idx    = (idx_q == IDX_W'(NUM_MINTERMS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            exp_q          <= '0;
            table_out      <= '0;
            match          <= 1'b0;
            mismatch_count <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q        <= SETTLE;
                        idx_q          <= '0;
                        exp_q          <= expected;
                        table_out      <= '0;
                        match          <= 1'b0;
                        mismatch_count <= '0;
                        fail_valid     <= 1'b0;
                        first_fail_idx <= '0;
                    end
                end
                SETTLE: begin
                    if (expire) begin
                        table_out <= sample_table;
                        if (sample_miss) begin
                            mismatch_count <= mismatch_count + 1'b1;
                            if (!fail_valid) begin
                                first_fail_idx <= idx_q;
                                fail_valid     <= 1'b1;
                            end
                        end
                        if (last_idx) begin
                            state_q <= DONE;
                            match   <= (sample_table == exp_q);
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign {a, b, c, d} = idx_q;
    assign busy         = (state_q == SETTLE);
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_bool_truth_table_scanner.sv
// Directed bench: two scanner instances (settle 1 and 3) each wrapped around
// a behavioural expression block selected per vector.
module tb_bool_truth_table_scanner;

    typedef struct {
        int          mode;
        logic [15:0] expv;
        logic [15:0] tbl;
        logic        mt;
        logic [4:0]  cnt;
        logic        fv;
        logic [3:0]  ff;
        int          s;
        bit          disturb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] expected = '0;
    bit          use3 = 1'b0;
    int          mode = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    logic        a1, b1, c1, d1, busy1, done1, match1, fv1;
    logic [15:0] tbl1;
    logic [4:0]  cnt1;
    logic [3:0]  ff1;
    logic        a3, b3, c3, d3, busy3, done3, match3, fv3;
    logic [15:0] tbl3;
    logic [4:0]  cnt3;
    logic [3:0]  ff3;
    logic        f1, f3;

    logic        o_busy, o_done, o_match, o_fv;
    logic [15:0] o_tbl;
    logic [4:0]  o_cnt;
    logic [3:0]  o_ff, o_abcd;

    always #5 clk = ~clk;

    function automatic logic model(input int md, input logic [3:0] m);
        logic va, vb, vc, vd;
        {va, vb, vc, vd} = m;
        case (md)
            0:       return (va & vb & vc) | (!va & !vc) | vd;
            1:       return (va & vb & !vc & vd) | (va & !vb & vc & vd) | (va & vb & !vc) | (va & vc);
            2:       return 1'b1;
            3:       return 1'b0;
            default: return vd;
        endcase
    endfunction

    assign f1 = model(mode, {a1, b1, c1, d1});
    assign f3 = model(mode, {a3, b3, c3, d3});

    bool_truth_table_scanner #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start & !use3), .expected(expected),
        .a(a1), .b(b1), .c(c1), .d(d1), .f_in(f1),
        .busy(busy1), .done(done1), .table_out(tbl1), .match(match1),
        .mismatch_count(cnt1), .fail_valid(fv1), .first_fail_idx(ff1)
    );

    bool_truth_table_scanner #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start & use3), .expected(expected),
        .a(a3), .b(b3), .c(c3), .d(d3), .f_in(f3),
        .busy(busy3), .done(done3), .table_out(tbl3), .match(match3),
        .mismatch_count(cnt3), .fail_valid(fv3), .first_fail_idx(ff3)
    );

    always_comb begin
        o_busy  = use3 ? busy3  : busy1;
        o_done  = use3 ? done3  : done1;
        o_match = use3 ? match3 : match1;
        o_fv    = use3 ? fv3    : fv1;
        o_tbl   = use3 ? tbl3   : tbl1;
        o_cnt   = use3 ? cnt3   : cnt1;
        o_ff    = use3 ? ff3    : ff1;
        o_abcd  = use3 ? {a3, b3, c3, d3} : {a1, b1, c1, d1};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_results(input vec_t v, input string tag);
        chk({tag, "_table"}, 32'(o_tbl), 32'(v.tbl));
        chk({tag, "_match"}, 32'(o_match), 32'(v.mt));
        chk({tag, "_count"}, 32'(o_cnt), 32'(v.cnt));
        chk({tag, "_fail_valid"}, 32'(o_fv), 32'(v.fv));
        chk({tag, "_first_fail"}, 32'(o_ff), 32'(v.ff));
    endtask

    task automatic run_scan(input vec_t v);
        int n;
        use3 = (v.s == 3);
        mode = v.mode;
        @(negedge clk);
        expected = v.expv;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 32'(o_busy), 32'd1);
        chk("abcd_first", 32'(o_abcd), 32'd0);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (v.disturb && n == 5) begin
                start    = 1'b1;
                expected = ~v.expv;
            end
            if (v.disturb && n == 6) start = 1'b0;
            if (o_done) break;
            if (v.s == 3) chk("abcd_hold", 32'(o_abcd), 32'(n / 3));
        end
        chk("done_latency", 32'(n), 32'(16 * v.s));
        chk("busy_in_done", 32'(o_busy), 32'd0);
        chk("abcd_in_done", 32'(o_abcd), 32'hF);
        check_results(v, "done");
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(o_done), 32'd0);
        chk("abcd_idle", 32'(o_abcd), 32'd0);
        check_results(v, "hold");
    endtask

    vec_t vecs[8];

    initial begin
        int n;
        bit seen;
        vecs[0] = '{0, 16'hEABB, 16'hEABB, 1'b1, 5'd0,  1'b0, 4'd0,  1, 1'b0};
        vecs[1] = '{0, 16'hEABA, 16'hEABB, 1'b0, 5'd1,  1'b1, 4'd0,  1, 1'b0};
        vecs[2] = '{1, 16'h0000, 16'hFC00, 1'b0, 5'd6,  1'b1, 4'd10, 1, 1'b0};
        vecs[3] = '{2, 16'hFFFF, 16'hFFFF, 1'b1, 5'd0,  1'b0, 4'd0,  3, 1'b0};
        vecs[4] = '{3, 16'hFFFF, 16'h0000, 1'b0, 5'd16, 1'b1, 4'd0,  1, 1'b0};
        vecs[5] = '{4, 16'h0000, 16'hAAAA, 1'b0, 5'd8,  1'b1, 4'd1,  1, 1'b0};
        vecs[6] = '{0, 16'hEABB, 16'hEABB, 1'b1, 5'd0,  1'b0, 4'd0,  1, 1'b1};
        vecs[7] = '{1, 16'hFC00, 16'hFC00, 1'b1, 5'd0,  1'b0, 4'd0,  3, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_dut1_ctl", {a1, b1, c1, d1, busy1, done1, match1, fv1, cnt1, ff1}, 32'd0);
        chk("reset_dut1_tbl", 32'(tbl1), 32'd0);
        chk("reset_dut3_ctl", {a3, b3, c3, d3, busy3, done3, match3, fv3, cnt3, ff3}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_scan(vecs[i]);

        // Reset in the middle of a scan while minterm 7 is driven.
        use3 = 1'b0;
        mode = 0;
        @(negedge clk);
        expected = 16'hEABA;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("abcd_before_rst", 32'(o_abcd), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_ctl", {o_abcd, o_busy, o_done, o_match, o_fv, o_cnt, o_ff}, 32'd0);
        chk("rst_async_tbl", 32'(o_tbl), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (o_done || o_busy) seen = 1'b1;
        end
        chk("no_done_after_rst", 32'(seen), 32'd0);
        run_scan(vecs[0]);

        // start held high: back-to-back scans with one IDLE cycle between.
        use3 = 1'b0;
        mode = 0;
        @(negedge clk);
        expected = 16'hEABB;
        start    = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!o_done && n < 100);
        chk("b2b_first_done", 32'(n), 32'd17);
        @(posedge clk);
        #1;
        chk("b2b_idle_gap", {o_busy, o_done}, 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_restart", 32'(o_busy), 32'd1);
        start = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!o_done && n < 100);
        chk("b2b_second_done", 32'(n), 32'd16);
        chk("b2b_match", 32'(o_match), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
